// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch buffer: packet geometry, entry type and
// the big-endian to RISC-V little-endian word swap.
package fetch_pkg;
  localparam int INST_W       = 32;
  localparam int PKT_W        = 64;
  localparam int INST_PER_PKT = 2;
  localparam int PC_W         = 32;

  // Default-width view of one queue entry (instruction plus its PC).
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  // Reverse byte order of a 32-bit word.
  function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/fetch_buffer_mem.sv
// DEPTH-entry instruction/PC storage: two write lanes at wr_ptr, wr_ptr+1 and
// two combinational read lanes at rd_ptr, rd_ptr+1. Contents are not reset.
module fetch_buffer_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic                                     clock_i,
  input  logic                                     we_i,
  input  logic [PW-1:0]                            wr_ptr_i,
  input  logic [INST_PER_PKT-1:0][INST_W-1:0]      wr_inst_i,
  input  logic [INST_PER_PKT-1:0][XLEN-1:0]        wr_pc_i,
  input  logic [PW-1:0]                            rd_ptr_i,
  output logic [INST_PER_PKT-1:0][INST_W-1:0]      rd_inst_o,
  output logic [INST_PER_PKT-1:0][XLEN-1:0]        rd_pc_o
);
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];

  // Write both lanes of a packet into consecutive slots; index wraps mod DEPTH.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      for (int l = 0; l < INST_PER_PKT; l++) begin
        inst_q[wr_ptr_i + PW'(l)] <= wr_inst_i[l];
        pc_q[wr_ptr_i + PW'(l)]   <= wr_pc_i[l];
      end
    end
  end

  for (genvar l = 0; l < INST_PER_PKT; l++) begin : g_rd
    assign rd_inst_o[l] = inst_q[rd_ptr_i + PW'(l)];
    assign rd_pc_o[l]   = pc_q[rd_ptr_i + PW'(l)];
  end
endmodule

// File: rtl/fetch_buffer.sv
// Dual-issue instruction queue behind the 64-bit imem. Swaps each fetched
// word into little-endian order, queues instruction/PC pairs and presents the
// two oldest to decode. Optional same-cycle bypass: FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       fetch_valid_i,
  input  logic [PKT_W-1:0]           fetch_data_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  output logic                       fetch_ready_o,
  input  logic                       flush_i,
  input  logic [1:0]                 dec_take_i,
  output logic                       dec0_valid_o,
  output logic [INST_W-1:0]          dec0_inst_o,
  output logic [XLEN-1:0]            dec0_pc_o,
  output logic                       dec1_valid_o,
  output logic [INST_W-1:0]          dec1_inst_o,
  output logic [XLEN-1:0]            dec1_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, avail;
  logic          ready_q, ready_d;
  logic          overflow, push;

  logic [INST_PER_PKT-1:0][INST_W-1:0] wr_inst, rd_inst;
  logic [INST_PER_PKT-1:0][XLEN-1:0]   wr_pc, rd_pc;
  logic [INST_W-1:0] d0_inst, d1_inst;
  logic [XLEN-1:0]   d0_pc, d1_pc;

  // Byte at fetch_pc sits in the top byte of the packet.
  assign wr_inst[0] = bswap32(fetch_data_i[63:32]);
  assign wr_inst[1] = bswap32(fetch_data_i[31:0]);
  assign wr_pc[0]   = fetch_pc_i;
  assign wr_pc[1]   = fetch_pc_i + XLEN'(4);

  // A packet that would not fit is dropped rather than corrupting the queue.
  assign overflow = count_q > CW'(DEPTH - 2);
  assign push     = fetch_valid_i && !flush_i && !overflow;

  fetch_buffer_mem #(.DEPTH(DEPTH), .XLEN(XLEN)) u_mem (
    .clock_i   (clock_i),
    .we_i      (push),
    .wr_ptr_i  (wr_ptr_q),
    .wr_inst_i (wr_inst),
    .wr_pc_i   (wr_pc),
    .rd_ptr_i  (rd_ptr_q),
    .rd_inst_o (rd_inst),
    .rd_pc_o   (rd_pc)
  );

`ifdef FETCH_BUFFER_BYPASS_EN
  // Incoming words fill whichever decode slots storage cannot. The whole
  // packet is still written: slots consumed this cycle fall behind rd_ptr
  // and are never read, which is equivalent to writing only untaken words.
  assign avail = count_q + (push ? CW'(2) : CW'(0));

  // Select stored or bypassed entries for the two decode slots.
  always_comb begin
    d0_inst = rd_inst[0];
    d0_pc   = rd_pc[0];
    d1_inst = rd_inst[1];
    d1_pc   = rd_pc[1];
    if (count_q == CW'(0)) begin
      d0_inst = wr_inst[0];
      d0_pc   = wr_pc[0];
      d1_inst = wr_inst[1];
      d1_pc   = wr_pc[1];
    end else if (count_q == CW'(1)) begin
      d1_inst = wr_inst[0];
      d1_pc   = wr_pc[0];
    end
  end
`else
  assign avail   = count_q;
  assign d0_inst = rd_inst[0];
  assign d0_pc   = rd_pc[0];
  assign d1_inst = rd_inst[1];
  assign d1_pc   = rd_pc[1];
`endif

  assign dec0_valid_o = avail >= CW'(1);
  assign dec1_valid_o = avail >= CW'(2);
  assign dec0_inst_o  = dec0_valid_o ? d0_inst : '0;
  assign dec0_pc_o    = dec0_valid_o ? d0_pc   : '0;
  assign dec1_inst_o  = dec1_valid_o ? d1_inst : '0;
  assign dec1_pc_o    = dec1_valid_o ? d1_pc   : '0;
  assign count_o      = count_q;
  assign fetch_ready_o = ready_q;

  // Next pointers/occupancy; flush wins over any same-cycle push or take.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(dec_take_i);
    wr_ptr_d = push ? wr_ptr_q + PW'(2) : wr_ptr_q;
    count_d  = count_q + (push ? CW'(2) : CW'(0)) - CW'(dec_take_i);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    // Leave a packet's worth of slack for the read already in flight.
    ready_d = count_d <= CW'(DEPTH - 4);
  end

  // Pointer, occupancy and ready state.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  a_take_legal: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    !flush_i |-> (dec_take_i != 2'd3 && CW'(dec_take_i) <= avail));
  a_no_overflow: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    !(fetch_valid_i && !flush_i && overflow));
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer (default build, no bypass).
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic              clock_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              fetch_valid_i = 1'b0;
  logic [63:0]       fetch_data_i = '0;
  logic [XLEN-1:0]   fetch_pc_i = '0;
  logic              fetch_ready_o;
  logic              flush_i = 1'b0;
  logic [1:0]        dec_take_i = '0;
  logic              dec0_valid_o, dec1_valid_o;
  logic [31:0]       dec0_inst_o, dec1_inst_o;
  logic [XLEN-1:0]   dec0_pc_o, dec1_pc_o;
  logic [3:0]        count_o;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .fetch_valid_i(fetch_valid_i), .fetch_data_i(fetch_data_i),
    .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .dec_take_i(dec_take_i),
    .dec0_valid_o(dec0_valid_o), .dec0_inst_o(dec0_inst_o), .dec0_pc_o(dec0_pc_o),
    .dec1_valid_o(dec1_valid_o), .dec1_inst_o(dec1_inst_o), .dec1_pc_o(dec1_pc_o),
    .count_o(count_o)
  );

  always #5 clock_i = ~clock_i;

  // Drive one cycle of stimulus, advance the scoreboard, sample #1 after edge.
  task automatic step(input bit v, input logic [63:0] d, input logic [31:0] pc,
                      input logic [1:0] take, input bit fl);
    entry_t e0, e1;
    fetch_valid_i = v; fetch_data_i = d; fetch_pc_i = pc;
    dec_take_i = take; flush_i = fl;
    e0.inst = {d[39:32], d[47:40], d[55:48], d[63:56]}; e0.pc = pc;
    e1.inst = {d[7:0], d[15:8], d[23:16], d[31:24]};    e1.pc = pc + 32'd4;
    @(posedge clock_i);
    if (fl) sb.delete();
    else begin
      for (int i = 0; i < take; i++) void'(sb.pop_front());
      if (v && sb.size() <= DEPTH - 2) begin sb.push_back(e0); sb.push_back(e1); end
    end
    #1;
    fetch_valid_i = 1'b0; dec_take_i = '0; flush_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i) reset_n_i = 1'b1;
    @(posedge clock_i); #1;
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    for (int i = 0; i < 3; i++) step(1, {32'h11000000 + i, 32'h22000000 + i}, 32'h40 + 8 * i, 0, 0);
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL reset_pre_count got %0d exp 6", count_o); end
    @(negedge clock_i) reset_n_i = 1'b0;
    #1;
    sb.delete();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_async_count got %0d exp 0", count_o); end
    checks++; if ({dec0_valid_o, dec1_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b exp 00", {dec0_valid_o, dec1_valid_o}); end
    checks++; if (dec0_inst_o !== 32'h0 || dec1_pc_o !== 32'h0) begin errors++; $display("FAIL reset_zero_out got %h/%h exp 0/0", dec0_inst_o, dec1_pc_o); end
    @(negedge clock_i) reset_n_i = 1'b1;
    @(posedge clock_i); #1;
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", fetch_ready_o); end
  endtask

  task automatic test_single;
    step(1, 64'h13000000_93001000, 32'h100, 0, 0);
    checks++; if (dec0_inst_o !== 32'h00000013 || dec0_pc_o !== 32'h100) begin errors++; $display("FAIL single_dec0 got %h@%h exp 00000013@100", dec0_inst_o, dec0_pc_o); end
    checks++; if (dec1_inst_o !== 32'h00100093 || dec1_pc_o !== 32'h104) begin errors++; $display("FAIL single_dec1 got %h@%h exp 00100093@104", dec1_inst_o, dec1_pc_o); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL single_count got %0d exp 2", count_o); end
    step(0, 0, 0, 2, 0);
    step(1, 64'h0, 32'h300, 0, 0);
    checks++; if (dec0_valid_o !== 1'b1 || dec0_inst_o !== 32'h0 || dec0_pc_o !== 32'h300) begin errors++; $display("FAIL zero_pkt got %b %h@%h exp 1 0@300", dec0_valid_o, dec0_inst_o, dec0_pc_o); end
    step(0, 0, 0, 2, 0);
    checks++; if (count_o !== 4'd0 || dec0_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got %0d/%b exp 0/0", count_o, dec0_valid_o); end
  endtask

  task automatic test_fill;
    logic [3:0] exp_c [3] = '{4'd2, 4'd4, 4'd6};
    logic       exp_r [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1, {32'hA0000000 + i, 32'hB0000000 + i}, 32'h1000 + 8 * i, 0, 0);
      checks++; if (count_o !== exp_c[i] || fetch_ready_o !== exp_r[i]) begin errors++; $display("FAIL fill_%0d got %0d/%b exp %0d/%b", i, count_o, fetch_ready_o, exp_c[i], exp_r[i]); end
    end
    step(0, 0, 0, 2, 0);
    checks++; if (count_o !== 4'd4 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL fill_take got %0d/%b exp 4/1", count_o, fetch_ready_o); end
    checks++; if (dec0_pc_o !== 32'h1008 || dec0_inst_o !== sb[0].inst) begin errors++; $display("FAIL fill_head got %h@%h exp %h@1008", dec0_inst_o, dec0_pc_o, sb[0].inst); end
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
  endtask

  task automatic test_concurrent;
    step(1, 64'h01020304_05060708, 32'h500, 0, 0);
    step(1, 64'h11121314_15161718, 32'h508, 1, 0);
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL conc_count got %0d exp 3", count_o); end
    checks++; if (dec0_inst_o !== 32'h08070605 || dec0_pc_o !== 32'h504) begin errors++; $display("FAIL conc_dec0 got %h@%h exp 08070605@504", dec0_inst_o, dec0_pc_o); end
    checks++; if (dec1_inst_o !== 32'h14131211 || dec1_pc_o !== 32'h508) begin errors++; $display("FAIL conc_dec1 got %h@%h exp 14131211@508", dec1_inst_o, dec1_pc_o); end
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) step(1, {32'hC0000000 + i, 32'hD0000000 + i}, 32'h700 + 8 * i, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", count_o); end
    step(1, 64'hDEADBEEF_CAFEF00D, 32'h900, 2, 1);
    checks++; if (count_o !== 4'd0 || dec0_valid_o !== 1'b0 || dec1_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL flush_state got %0d %b%b %b exp 0 00 1", count_o, dec0_valid_o, dec1_valid_o, fetch_ready_o); end
    step(1, 64'h13000000_93001000, 32'h200, 0, 0);
    checks++; if (dec0_pc_o !== 32'h200 || dec0_inst_o !== 32'h00000013 || count_o !== 4'd2) begin errors++; $display("FAIL flush_next got %h@%h c%0d exp 00000013@200 c2", dec0_inst_o, dec0_pc_o, count_o); end
    step(0, 0, 0, 2, 0);
  endtask

  task automatic test_wrap;
    logic [31:0] prev_pc;
    int bad = 0;
    step(1, {32'h0, 32'h1}, 32'h2000, 0, 0);
    prev_pc = dec0_pc_o;
    checks++; if (prev_pc !== 32'h2000) begin errors++; $display("FAIL wrap_first got %h exp 2000", prev_pc); end
    for (int i = 1; i < 12; i++) begin
      step(1, {$urandom, $urandom}, 32'h2000 + 8 * i, 2, 0);
      if (dec0_pc_o !== prev_pc + 32'd8 || dec0_inst_o !== sb[0].inst || dec1_inst_o !== sb[1].inst) bad++;
      prev_pc = dec0_pc_o;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_seq got %0d bad steps exp 0", bad); end
    checks++; if (prev_pc !== 32'h2058 || count_o !== 4'd2) begin errors++; $display("FAIL wrap_last got %h c%0d exp 2058 c2", prev_pc, count_o); end
    step(0, 0, 0, 2, 0);
  endtask

  task automatic test_random;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      bit v, fl;
      int mx;
      logic [1:0] t;
      v  = (sb.size() <= DEPTH - 4) && ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      mx = (sb.size() < 2) ? sb.size() : 2;
      t  = 2'($urandom_range(0, mx));
      step(v, {$urandom, $urandom}, $urandom, t, fl);
      if (count_o !== 4'(sb.size())) bad++;
      if (fetch_ready_o !== (sb.size() <= DEPTH - 4)) bad++;
      if (dec0_valid_o !== (sb.size() >= 1) || dec1_valid_o !== (sb.size() >= 2)) bad++;
      if (sb.size() >= 1 && {dec0_inst_o, dec0_pc_o} !== sb[0]) bad++;
      if (sb.size() >= 2 && {dec1_inst_o, dec1_pc_o} !== sb[1]) bad++;
      if (sb.size() == 0 && dec0_inst_o !== 32'h0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random got %0d mismatching samples exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_concurrent();
    test_flush();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
